rot_frame_ctrl: RTL and testbench
=================================

// Module: rot_frame_ctrl
// PURPOSE
//   Frame sequencer for the image-rotate path. Owns the single-port 32-bit frame SRAM.
//   LOAD phase: writes one raster-order input frame at addr {4'b0,x,y}.
//   DRAIN phase: reads the frame back in rotated raster order (0/90/180/270 CW) onto a
//   valid/ready output stream. Sits between pixel ingest and the output formatter.
// PARAMETERS
//   XW      8   column index width (max width 2^XW)
//   YW      8   row index width (max height 2^YW)
//   ADDR_W  20  SRAM address width; addr = {zero-pad, x, y}
//   PIX_W   24  pixel width (8-bit RGB); SRAM word = {8'b0, pixel}
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset, asynchronous, active-high
//   start      in   1       begin frame; sampled only in IDLE
//   cfg_w_m1   in   XW      source width-1; latched at start
//   cfg_h_m1   in   YW      source height-1; latched at start
//   cfg_rot    in   2       0=0deg, 1=90CW, 2=180, 3=270CW; latched at start
//   busy       out  1       high from the cycle after start until the done cycle
//   done       out  1       one-cycle pulse after the last output pixel is accepted
//   err        out  1       sticky: in_eol disagreed with the column counter; cleared by start
//   in_valid   in   1       input pixel valid
//   in_ready   out  1       high throughout LOAD
//   in_data    in   PIX_W   input pixel
//   in_eol     in   1       input end-of-line marker (checked only)
//   out_valid  out  1       output pixel valid
//   out_ready  in   1       downstream accept
//   out_data   out  PIX_W   output pixel
//   out_sof    out  1       first pixel of the output frame
//   out_eol    out  1       last pixel of each output row
//   mem_en     out  1       SRAM enable
//   mem_we     out  1       SRAM write enable
//   mem_addr   out  ADDR_W  SRAM address
//   mem_wdata  out  32      SRAM write data
//   mem_rdata  in   32      SRAM read data; valid one cycle after the read edge
// BEHAVIOUR
//   Reset: state=IDLE. All outputs are 0 (busy, done, err, in_ready, out_*, mem_*).
//     Output FIFO is flushed; counters are 0. SRAM contents are not cleared.
//   States: IDLE -start-> LOAD -last write-> DRAIN -last accept-> DONE -> IDLE.
//   start while not IDLE is ignored.
//   LOAD: mem_* are combinational from the handshake.
//     - Each in_valid&in_ready cycle: mem_en=mem_we=1, addr={0,x,y}, wdata={8'b0,in_data}.
//     - x increments; at x==w_m1, x wraps to 0 and y increments.
//     - in_eol != (x==w_m1) on a handshake sets err.
//     - The write at (w_m1,h_m1) moves the state to DRAIN.
//   DRAIN: output scan (ox fastest) maps to source (sx,sy):
//     rot0: (ox,oy)   rot90: (oy, h_m1-ox)   rot180: (w_m1-ox, h_m1-oy)   rot270: (w_m1-oy, ox)
//     Output width = W for rot0/rot180, H for rot90/rot270; output height is the other dimension.
//   Read issue:
//     - A read is issued (mem_en=1, we=0) only if FIFO occupancy + in-flight reads < 2.
//     - Returned data is pushed next cycle with its sof/eol tags.
//     - sof is set for output (0,0); eol is set for ox==last column.
//   FIFO: 2 entries; out_valid = not empty; push and pop in the same cycle is allowed when full.
//   Throughput: 1 pixel/clk in both phases when in_valid and out_ready are held high.
//   Latency: first out_valid is 2 cycles after the last input handshake.
//   Done: after the last read is issued, leave DRAIN when the FIFO drains and the final
//     pixel is accepted. DONE asserts done for 1 cycle, then returns to IDLE.
//   Mid-operation reset: immediate return to IDLE; any partial frame is abandoned.
//   1x1 frame: one write, one read; the output pixel carries sof=1 and eol=1.
// STRUCTURE
//   rot_pkg: rot_e (ROT_0/90/180/270), state_e, ADDR_PAD = ADDR_W-XW-YW.
//   Sub-module rot_out_fifo: 2-entry FIFO of {sof, eol, PIX_W data} with count output.
//   The top level holds the FSM, load/drain counters, rotate address mapping and credit logic.
// TESTING
//   1. 4x3 frame, rot0, pixel = y*4+x, out_ready=1 -> out 0..11; eol on 3,7,11;
//      sof on 0; single done pulse.
//   2. Same frame, rot90 -> rows {8,4,0},{9,5,1},{10,6,2},{11,7,3}; eol on every 3rd pixel.
//   3. Same frame, rot270, out_ready toggling 1,0 and a start pulse mid-DRAIN ->
//      out {3,7,11},{2,6,10},{1,5,9},{0,4,8}; no drop or duplicate; start ignored;
//      mem_en=0 while the FIFO is full.
//   4. 1x1 frame, rot180, pixel 24'hABCDEF -> one beat, data ABCDEF, sof=1, eol=1, then done.
//   5. rst asserted at the 5th output pixel -> all outputs 0 asynchronously;
//      a following 2x2 rot0 frame completes correctly.
//   6. 4x3 frame with in_eol asserted at x=2 of row 1 -> err=1 held through DRAIN;
//      the next start clears it.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and constants for the image-rotate frame sequencer.
package rot_pkg;

  localparam int XW_DEF     = 8;
  localparam int YW_DEF     = 8;
  localparam int ADDR_W_DEF = 20;
  localparam int PIX_W_DEF  = 24;
  localparam int ADDR_PAD   = ADDR_W_DEF - XW_DEF - YW_DEF;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_e;

  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE  = 2'd0;
  localparam state_e ST_LOAD  = 2'd1;
  localparam state_e ST_DRAIN = 2'd2;
  localparam state_e ST_DONE  = 2'd3;

  // A read may be issued when the FIFO slots not yet claimed by stored or
  // in-flight pixels leave room. A pop in the same cycle frees a slot, but never
  // while the FIFO is full, so a full FIFO always blocks the SRAM.
  function automatic logic read_credit(input logic [1:0] fifo_cnt,
                                       input logic       inflight,
                                       input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, fifo_cnt} + {2'b00, inflight};
    if (occ < 3'd2) begin
      read_credit = 1'b1;
    end else if (pop && (occ == 3'd2) && (fifo_cnt != 2'd2)) begin
      read_credit = 1'b1;
    end else begin
      read_credit = 1'b0;
    end
  endfunction

endpackage

// File: rtl/rot_frame_ctrl_if.sv
// Pixel-in stream, pixel-out stream and frame SRAM port of the rotate sequencer.
interface rot_frame_ctrl_if #(
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 20
);
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_data;
  logic              in_eol;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_data;
  logic              out_sof;
  logic              out_eol;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  in_valid, in_data, in_eol, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, out_sof, out_eol,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, in_eol, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, out_sof, out_eol,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rot_out_fifo.sv
// Two-entry output FIFO holding {sof, eol, pixel}; push while full is accepted
// only together with a pop.
module rot_out_fifo #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);
  logic [W-1:0] slot0_r;
  logic [W-1:0] slot1_r;
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         do_pop_s;
  logic         do_push_s;

  assign do_pop_s  = pop && (count_r != 2'd0);
  assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_r  <= {W{1'b0}};
      slot1_r  <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        if (wr_ptr_r) begin
          slot1_r <= push_data;
        end else begin
          slot0_r <= push_data;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = rd_ptr_r ? slot1_r : slot0_r;
  assign count    = count_r;

endmodule

// File: rtl/rot_frame_ctrl.sv
// Frame sequencer for the image-rotate path: loads one raster frame into the
// frame SRAM, then streams it back out in 0/90/180/270 degree CW order.
module rot_frame_ctrl
  import rot_pkg::*;
#(
  parameter int XW     = XW_DEF,
  parameter int YW     = YW_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XW-1:0]    cfg_w_m1,
  input  logic [YW-1:0]    cfg_h_m1,
  input  logic [1:0]       cfg_rot,
  output logic             busy,
  output logic             done,
  output logic             err,
  rot_frame_ctrl_if.master bus
);
  localparam int CW    = (XW > YW) ? XW : YW;
  localparam int PAD_W = ADDR_W - XW - YW;
  localparam int FW    = PIX_W + 2;

  state_e        state_r;
  logic [XW-1:0] w_m1_r;
  logic [YW-1:0] h_m1_r;
  rot_e          rot_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [CW-1:0] ox_r;
  logic [CW-1:0] oy_r;
  logic          rd_all_r;
  logic          inflight_r;
  logic          rd_sof_r;
  logic          rd_eol_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic          in_hs_s;
  logic          x_last_s;
  logic          y_last_s;
  logic          pop_s;
  logic          rd_issue_s;
  logic          last_pop_s;
  logic [1:0]    fifo_cnt_s;
  logic [FW-1:0] fifo_dout_s;
  logic [CW-1:0] w_ext_s;
  logic [CW-1:0] h_ext_s;
  logic [CW-1:0] ow_m1_s;
  logic [CW-1:0] oh_m1_s;
  logic          ox_last_s;
  logic          oy_last_s;
  logic [CW-1:0] sx_c_s;
  logic [CW-1:0] sy_c_s;
  logic [XW-1:0] sx_s;
  logic [YW-1:0] sy_s;
  logic          unused_rdata_s;

  assign in_hs_s    = (state_r == ST_LOAD) && bus.in_valid;
  assign x_last_s   = (x_r == w_m1_r);
  assign y_last_s   = (y_r == h_m1_r);
  assign pop_s      = bus.out_valid && bus.out_ready;
  assign rd_issue_s = (state_r == ST_DRAIN) && !rd_all_r &&
                      read_credit(fifo_cnt_s, inflight_r, pop_s);
  assign last_pop_s = rd_all_r && !inflight_r && pop_s && (fifo_cnt_s == 2'd1);

  // Output scan dimensions swap for the quarter-turn rotations.
  assign w_ext_s   = CW'(w_m1_r);
  assign h_ext_s   = CW'(h_m1_r);
  assign ow_m1_s   = rot_r[0] ? h_ext_s : w_ext_s;
  assign oh_m1_s   = rot_r[0] ? w_ext_s : h_ext_s;
  assign ox_last_s = (ox_r == ow_m1_s);
  assign oy_last_s = (oy_r == oh_m1_s);

  // Map the output scan position to the source pixel it shows.
  always_comb begin
    sx_c_s = ox_r;
    sy_c_s = oy_r;
    case (rot_r)
      ROT_0: begin
        sx_c_s = ox_r;
        sy_c_s = oy_r;
      end
      ROT_90: begin
        sx_c_s = oy_r;
        sy_c_s = h_ext_s - ox_r;
      end
      ROT_180: begin
        sx_c_s = w_ext_s - ox_r;
        sy_c_s = h_ext_s - oy_r;
      end
      ROT_270: begin
        sx_c_s = w_ext_s - oy_r;
        sy_c_s = ox_r;
      end
      default: begin
        sx_c_s = ox_r;
        sy_c_s = oy_r;
      end
    endcase
  end

  assign sx_s = sx_c_s[XW-1:0];
  assign sy_s = sy_c_s[YW-1:0];

  // SRAM port: writes follow the input handshake, reads follow the credit check.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = 32'h0000_0000;
    if (in_hs_s) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = {{PAD_W{1'b0}}, x_r, y_r};
      bus.mem_wdata = {{(32-PIX_W){1'b0}}, bus.in_data};
    end else if (rd_issue_s) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {{PAD_W{1'b0}}, sx_s, sy_s};
      bus.mem_wdata = 32'h0000_0000;
    end else begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = 32'h0000_0000;
    end
  end

  // Frame FSM with load/drain counters, status flags and config latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      w_m1_r   <= {XW{1'b0}};
      h_m1_r   <= {YW{1'b0}};
      rot_r    <= ROT_0;
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
      ox_r     <= {CW{1'b0}};
      oy_r     <= {CW{1'b0}};
      rd_all_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_LOAD;
            w_m1_r   <= cfg_w_m1;
            h_m1_r   <= cfg_h_m1;
            rot_r    <= rot_e'(cfg_rot);
            x_r      <= {XW{1'b0}};
            y_r      <= {YW{1'b0}};
            ox_r     <= {CW{1'b0}};
            oy_r     <= {CW{1'b0}};
            rd_all_r <= 1'b0;
            busy_r   <= 1'b1;
            err_r    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_hs_s) begin
            err_r <= err_r | (bus.in_eol != x_last_s);
            if (x_last_s) begin
              x_r <= {XW{1'b0}};
              if (y_last_s) begin
                state_r <= ST_DRAIN;
              end else begin
                y_r <= y_r + {{(YW-1){1'b0}}, 1'b1};
              end
            end else begin
              x_r <= x_r + {{(XW-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DRAIN: begin
          if (rd_issue_s) begin
            if (ox_last_s) begin
              ox_r <= {CW{1'b0}};
              if (oy_last_s) begin
                rd_all_r <= 1'b1;
              end else begin
                oy_r <= oy_r + {{(CW-1){1'b0}}, 1'b1};
              end
            end else begin
              ox_r <= ox_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end
          if (last_pop_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-return tracking: the SRAM answers one cycle after the read edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
      rd_sof_r   <= 1'b0;
      rd_eol_r   <= 1'b0;
    end else begin
      inflight_r <= rd_issue_s;
      if (rd_issue_s) begin
        rd_sof_r <= (ox_r == {CW{1'b0}}) && (oy_r == {CW{1'b0}});
        rd_eol_r <= ox_last_s;
      end
    end
  end

  rot_out_fifo #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data ({rd_sof_r, rd_eol_r, bus.mem_rdata[PIX_W-1:0]}),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .count     (fifo_cnt_s)
  );

  assign unused_rdata_s = ^bus.mem_rdata[31:PIX_W];

  assign bus.in_ready  = (state_r == ST_LOAD);
  assign bus.out_valid = (fifo_cnt_s != 2'd0);
  assign bus.out_sof   = fifo_dout_s[PIX_W+1];
  assign bus.out_eol   = fifo_dout_s[PIX_W];
  assign bus.out_data  = fifo_dout_s[PIX_W-1:0];
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_rot_frame_ctrl.sv
// Self-checking bench for rot_frame_ctrl: table of frames plus reset/abort sequence.
module tb_rot_frame_ctrl;

  typedef struct {
    logic [7:0]  w_m1;
    logic [7:0]  h_m1;
    logic [1:0]  rot;
    logic [23:0] base;
    bit          tog;
    bit          mid_start;
    int          bad_x;
    int          bad_y;
    int          abort_beat;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_w_m1;
  logic [7:0]  cfg_h_m1;
  logic [1:0]  cfg_rot;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] sram [0:65535];
  logic [31:0] rdata_r;
  logic [25:0] sb_q [$];
  vec_t        vecs [9];
  int          checks   = 0;
  int          failures = 0;

  rot_frame_ctrl_if #(.PIX_W(24), .ADDR_W(20)) bus ();

  rot_frame_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_w_m1 (cfg_w_m1),
    .cfg_h_m1 (cfg_h_m1),
    .cfg_rot  (cfg_rot),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = rdata_r;

  // Single-port SRAM model, read data valid one cycle after the read edge.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr[15:0]] <= bus.mem_wdata;
      else            rdata_r <= sram[bus.mem_addr[15:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected output stream: rows of the rotated image, in output raster order.
  task automatic build_expected(input vec_t v);
    int w, h, no, ni, x, y;
    bit first;
    w = int'(v.w_m1) + 1;
    h = int'(v.h_m1) + 1;
    no = (v.rot[0]) ? w : h;
    ni = (v.rot[0]) ? h : w;
    first = 1'b1;
    for (int o = 0; o < no; o++) begin
      for (int i = 0; i < ni; i++) begin
        case (v.rot)
          2'd0:    begin x = i;         y = o;         end
          2'd1:    begin x = o;         y = h - 1 - i; end  // column o read bottom-up
          2'd2:    begin x = w - 1 - i; y = h - 1 - o; end
          default: begin x = w - 1 - o; y = i;         end  // column w-1-o read top-down
        endcase
        sb_q.push_back({first, (i == ni - 1), v.base + 24'(y * w + x)});
        first = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, 64'({busy, done, err, bus.in_ready, bus.out_valid, bus.out_sof,
                              bus.out_eol, bus.mem_en, bus.mem_we}), 64'd0);
    check({name, "_bus"}, 64'({bus.out_data, bus.mem_addr}), 64'd0);
    check({name, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
  endtask

  task automatic run_row(input vec_t v);
    int w, h, n, k, beats, first_lat, load_viol, occ_viol, full_viol, occ;
    bit iq1, iq2, pq, iss, pop, got_done, aborted;
    logic [23:0] first_d, last_d;
    logic [25:0] exp_e;
    w = int'(v.w_m1) + 1;
    h = int'(v.h_m1) + 1;
    n = w * h;
    sb_q.delete();
    build_expected(v);
    @(negedge clk);
    cfg_w_m1 = v.w_m1; cfg_h_m1 = v.h_m1; cfg_rot = v.rot; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy_ready_err", 64'({busy, bus.in_ready, err}), 64'(3'b110));
    load_viol = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = v.base + 24'(y * w + x);
        bus.in_eol   = (x == w - 1) ^ ((x == v.bad_x) && (y == v.bad_y));
        #1;
        if (!(bus.mem_en && bus.mem_we && (bus.mem_addr == {4'h0, 8'(x), 8'(y)}) &&
              (bus.mem_wdata == {8'h00, bus.in_data}))) load_viol++;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_eol   = 1'b0;
    check("load_writes_bad", 64'(load_viol), 64'd0);
    check("err_in_drain", 64'(err), 64'(v.exp_err));
    k = 0; beats = 0; first_lat = -1; occ_viol = 0; full_viol = 0; occ = 0;
    iq1 = 1'b0; iq2 = 1'b0; pq = 1'b0; got_done = 1'b0; aborted = 1'b0;
    first_d = 24'h0; last_d = 24'h0;
    while (!got_done && !aborted && (k < 300)) begin
      occ = occ + int'(iq2) - int'(pq);
      if (done) begin
        got_done = 1'b1;
      end else if ((v.abort_beat > 0) && (beats == v.abort_beat - 1) && bus.out_valid) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_reset");
        sb_q.delete();
        aborted = 1'b1;
      end else begin
        if (bus.out_valid != (occ != 0)) occ_viol++;
        if (bus.out_valid && (first_lat < 0)) first_lat = k;
        bus.out_ready = v.tog ? (k % 2 == 0) : 1'b1;
        start = v.mid_start && (k == 5);
        #1;
        iss = bus.mem_en && !bus.mem_we;
        if (iss && (occ == 2)) full_viol++;
        pop = bus.out_valid && bus.out_ready;
        if (pop) begin
          check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            exp_e = sb_q.pop_front();
            check("beat", 64'({bus.out_sof, bus.out_eol, bus.out_data}), 64'(exp_e));
          end
          if (beats == 0) first_d = bus.out_data;
          last_d = bus.out_data;
          beats++;
        end
        iq2 = iq1; iq1 = iss; pq = pop;
        k++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_abort", 64'({busy, bus.in_ready, bus.out_valid}), 64'd0);
    end else begin
      check("done_seen", 64'(got_done), 64'd1);
      check("beat_count", 64'(beats), 64'(n));
      check("first_pixel", 64'(first_d), 64'(v.exp_first));
      check("last_pixel", 64'(last_d), 64'(v.exp_last));
      check("latency", 64'(first_lat), 64'd2);
      check("valid_vs_occupancy", 64'(occ_viol), 64'd0);
      check("read_while_full", 64'(full_viol), 64'd0);
      check("sb_left", 64'(sb_q.size()), 64'd0);
      check("err_at_done", 64'(err), 64'(v.exp_err));
      if (!v.tog) check("throughput_cycles", 64'(k), 64'(n + 2));
      @(negedge clk);
      check("after_done", 64'({done, busy, bus.out_valid}), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_w_m1 = 8'd0; cfg_h_m1 = 8'd0; cfg_rot = 2'd0;
    bus.in_valid = 1'b0; bus.in_data = 24'h0; bus.in_eol = 1'b0; bus.out_ready = 1'b0;
    //          w_m1   h_m1   rot    base        tog   mid   bx  by  abort first       last        err
    vecs[0] = '{8'd3, 8'd2, 2'd0, 24'h000000, 1'b0, 1'b0, -1, -1, 0, 24'd0,      24'd11,     1'b0};
    vecs[1] = '{8'd3, 8'd2, 2'd1, 24'h000000, 1'b0, 1'b0, -1, -1, 0, 24'd8,      24'd3,      1'b0};
    vecs[2] = '{8'd3, 8'd2, 2'd3, 24'h000000, 1'b1, 1'b1, -1, -1, 0, 24'd3,      24'd8,      1'b0};
    vecs[3] = '{8'd0, 8'd0, 2'd2, 24'hABCDEF, 1'b0, 1'b0, -1, -1, 0, 24'hABCDEF, 24'hABCDEF, 1'b0};
    vecs[4] = '{8'd3, 8'd2, 2'd0, 24'h000000, 1'b0, 1'b0,  2,  1, 0, 24'd0,      24'd11,     1'b1};
    vecs[5] = '{8'd3, 8'd2, 2'd2, 24'h000000, 1'b0, 1'b0, -1, -1, 0, 24'd11,     24'd0,      1'b0};
    vecs[6] = '{8'd2, 8'd1, 2'd1, 24'h000000, 1'b1, 1'b0, -1, -1, 0, 24'd3,      24'd2,      1'b0};
    vecs[7] = '{8'd3, 8'd2, 2'd0, 24'h000000, 1'b0, 1'b0, -1, -1, 5, 24'd0,      24'd11,     1'b0};
    vecs[8] = '{8'd1, 8'd1, 2'd0, 24'h000100, 1'b0, 1'b0, -1, -1, 0, 24'h000100, 24'h000103, 1'b0};
    repeat (2) @(negedge clk);
    check_reset_outputs("power_on_reset");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_row(vecs[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
